// File: rtl/multi_ball_hit_controller.sv
// Frame-based collision arbiter for up to eight balls. Overlap events are
// gathered during the frame; on startOfFrame the pairs are resolved one per
// cycle, then per-ball hole/pair/border priority is applied and the resolved
// velocities are published with a one-cycle resultValid strobe.
module multi_ball_hit_controller #(
  parameter int NUM_BALLS    = 4,
  parameter int BALL_SIZE    = 32,
  parameter int TOP_OFFSET   = 0,
  parameter int DOWN_OFFSET  = 479,
  parameter int LEFT_OFFSET  = 0,
  parameter int RIGHT_OFFSET = 639,
  parameter int EDGE_MARGIN  = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [NUM_BALLS-1:0]     ballDR,
  input  logic                     bordersDR,
  input  logic                     holesDR,
  input  logic [2:0]               holeNumber,
  input  logic [11*NUM_BALLS-1:0]  ballPosX,
  input  logic [11*NUM_BALLS-1:0]  ballPosY,
  input  logic [11*NUM_BALLS-1:0]  ballVelX,
  input  logic [11*NUM_BALLS-1:0]  ballVelY,
  output logic [11*NUM_BALLS-1:0]  ballVelXOut,
  output logic [11*NUM_BALLS-1:0]  ballVelYOut,
  output logic [NUM_BALLS-1:0]     collisionOccurred,
  output logic [NUM_BALLS-1:0]     holeHit,
  output logic [3*NUM_BALLS-1:0]   holeNum,
  output logic                     resultValid,
  output logic                     busy
);

  localparam int P  = NUM_BALLS * (NUM_BALLS - 1) / 2;
  localparam int BW = $clog2(NUM_BALLS);
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  // Cushion thresholds, evaluated in 12-bit unsigned so pos+size never wraps
  localparam logic [11:0] LEFT_LIM  = 12'(LEFT_OFFSET + EDGE_MARGIN);
  localparam logic [11:0] RIGHT_LIM = 12'(RIGHT_OFFSET - EDGE_MARGIN);
  localparam logic [11:0] TOP_LIM   = 12'(TOP_OFFSET + EDGE_MARGIN);
  localparam logic [11:0] DOWN_LIM  = 12'(DOWN_OFFSET - EDGE_MARGIN);
  localparam logic [11:0] SIZE_M1   = 12'(BALL_SIZE - 1);

  typedef enum logic [1:0] {COLLECT, RESOLVE, APPLY} state_t;

  state_t                 state_reg;
  logic [PW-1:0]          pair_idx_reg;
  logic [BW-1:0]          pi_reg, pj_reg;

  // Sticky per-frame event flags
  logic [NUM_BALLS-1:0]   border_hit_reg, hole_pend_reg;
  logic [2:0]             hole_num_reg [NUM_BALLS];
  logic [P-1:0]           pair_hit_reg;
  logic [P-1:0]           pair_now;

  // Working copies snapshotted at frame start
  logic [10:0]            pos_x_reg [NUM_BALLS];
  logic [10:0]            pos_y_reg [NUM_BALLS];
  logic signed [10:0]     vel_x_reg [NUM_BALLS];
  logic signed [10:0]     vel_y_reg [NUM_BALLS];
  logic [NUM_BALLS-1:0]   claimed_reg;

  // Registered outputs
  logic signed [10:0]     vel_x_out_reg [NUM_BALLS];
  logic signed [10:0]     vel_y_out_reg [NUM_BALLS];
  logic [2:0]             hole_num_out_reg [NUM_BALLS];
  logic [NUM_BALLS-1:0]   coll_out_reg, hole_out_reg;
  logic                   valid_reg, busy_reg;

  // Per-ball results of the APPLY priority logic
  logic signed [10:0]     apply_vx [NUM_BALLS];
  logic signed [10:0]     apply_vy [NUM_BALLS];
  logic [2:0]             apply_hn [NUM_BALLS];
  logic [NUM_BALLS-1:0]   apply_coll;

  // Negation that maps the most negative value onto the most positive one
  function automatic logic signed [10:0] sat_neg(input logic signed [10:0] v);
    return (v == 11'sh400) ? 11'sh3FF : -v;
  endfunction

  genvar gi, gj;

  // Pair overlap this cycle, laid out in lexicographic (i,j) order
  generate
    for (gi = 0; gi < NUM_BALLS; gi++) begin : g_pi
      for (gj = gi + 1; gj < NUM_BALLS; gj++) begin : g_pj
        localparam int PIDX = gi * NUM_BALLS - gi * (gi + 1) / 2 + (gj - gi - 1);
        assign pair_now[PIDX] = ballDR[gi] & ballDR[gj];
      end
    end
  endgenerate

  // Accumulate events while collecting; clear them when APPLY finishes
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      border_hit_reg <= '0;
      hole_pend_reg  <= '0;
      pair_hit_reg   <= '0;
      for (int i = 0; i < NUM_BALLS; i++) hole_num_reg[i] <= '0;
    end else if (state_reg == COLLECT) begin
      border_hit_reg <= border_hit_reg | (ballDR & {NUM_BALLS{bordersDR}});
      hole_pend_reg  <= hole_pend_reg  | (ballDR & {NUM_BALLS{holesDR}});
      pair_hit_reg   <= pair_hit_reg | pair_now;
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (ballDR[i] && holesDR && !hole_pend_reg[i]) hole_num_reg[i] <= holeNumber;
      end
    end else if (state_reg == APPLY) begin
      border_hit_reg <= '0;
      hole_pend_reg  <= '0;
      pair_hit_reg   <= '0;
      for (int i = 0; i < NUM_BALLS; i++) hole_num_reg[i] <= '0;
    end
  end

  // Frame FSM: snapshot, pair-by-pair resolution, registered publish
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= COLLECT;
      pair_idx_reg <= '0;
      pi_reg       <= '0;
      pj_reg       <= BW'(1);
      claimed_reg  <= '0;
      coll_out_reg <= '0;
      hole_out_reg <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        pos_x_reg[i]        <= '0;
        pos_y_reg[i]        <= '0;
        vel_x_reg[i]        <= '0;
        vel_y_reg[i]        <= '0;
        vel_x_out_reg[i]    <= '0;
        vel_y_out_reg[i]    <= '0;
        hole_num_out_reg[i] <= '0;
      end
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (startOfFrame) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
              pos_x_reg[i] <= ballPosX[i*11 +: 11];
              pos_y_reg[i] <= ballPosY[i*11 +: 11];
              vel_x_reg[i] <= $signed(ballVelX[i*11 +: 11]);
              vel_y_reg[i] <= $signed(ballVelY[i*11 +: 11]);
            end
            pair_idx_reg <= '0;
            pi_reg       <= '0;
            pj_reg       <= BW'(1);
            claimed_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= RESOLVE;
          end
        end
        RESOLVE: begin
          // A ball already in a hole or already paired this frame is skipped
          if (pair_hit_reg[pair_idx_reg] && !hole_pend_reg[pi_reg] && !hole_pend_reg[pj_reg]
              && !claimed_reg[pi_reg] && !claimed_reg[pj_reg]) begin
            vel_x_reg[pi_reg]   <= vel_x_reg[pj_reg];
            vel_y_reg[pi_reg]   <= vel_y_reg[pj_reg];
            vel_x_reg[pj_reg]   <= vel_x_reg[pi_reg];
            vel_y_reg[pj_reg]   <= vel_y_reg[pi_reg];
            claimed_reg[pi_reg] <= 1'b1;
            claimed_reg[pj_reg] <= 1'b1;
          end
          if (pair_idx_reg == PW'(P - 1)) begin
            state_reg <= APPLY;
          end else begin
            pair_idx_reg <= pair_idx_reg + PW'(1);
            if (pj_reg == BW'(NUM_BALLS - 1)) begin
              pi_reg <= pi_reg + BW'(1);
              pj_reg <= pi_reg + BW'(2);
            end else begin
              pj_reg <= pj_reg + BW'(1);
            end
          end
        end
        APPLY: begin
          for (int i = 0; i < NUM_BALLS; i++) begin
            vel_x_out_reg[i]    <= apply_vx[i];
            vel_y_out_reg[i]    <= apply_vy[i];
            hole_num_out_reg[i] <= apply_hn[i];
          end
          coll_out_reg <= apply_coll;
          hole_out_reg <= hole_pend_reg;
          valid_reg    <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= COLLECT;
        end
        default: begin
          state_reg <= COLLECT;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Per-ball priority: hole beats pair, pair beats cushion bounce
  generate
    for (gi = 0; gi < NUM_BALLS; gi++) begin : g_apply
      logic at_left, at_right, at_top, at_bottom, flip_x, flip_y, bounce;
      assign at_left   = {1'b0, pos_x_reg[gi]} <= LEFT_LIM;
      assign at_right  = ({1'b0, pos_x_reg[gi]} + SIZE_M1) >= RIGHT_LIM;
      assign at_top    = {1'b0, pos_y_reg[gi]} <= TOP_LIM;
      assign at_bottom = ({1'b0, pos_y_reg[gi]} + SIZE_M1) >= DOWN_LIM;
      assign flip_x = (at_left && vel_x_reg[gi][10]) ||
                      (at_right && !vel_x_reg[gi][10] && (vel_x_reg[gi] != '0));
      assign flip_y = (at_top && vel_y_reg[gi][10]) ||
                      (at_bottom && !vel_y_reg[gi][10] && (vel_y_reg[gi] != '0));
      assign bounce = border_hit_reg[gi] && !claimed_reg[gi] && !hole_pend_reg[gi];
      assign apply_vx[gi] = hole_pend_reg[gi] ? '0 :
                            (bounce && flip_x) ? sat_neg(vel_x_reg[gi]) : vel_x_reg[gi];
      assign apply_vy[gi] = hole_pend_reg[gi] ? '0 :
                            (bounce && flip_y) ? sat_neg(vel_y_reg[gi]) : vel_y_reg[gi];
      assign apply_coll[gi] = !hole_pend_reg[gi] && (claimed_reg[gi] || border_hit_reg[gi]);
      assign apply_hn[gi]   = hole_pend_reg[gi] ? hole_num_reg[gi] : 3'd0;

      assign ballVelXOut[gi*11 +: 11] = vel_x_out_reg[gi];
      assign ballVelYOut[gi*11 +: 11] = vel_y_out_reg[gi];
      assign holeNum[gi*3 +: 3]       = hole_num_out_reg[gi];
    end
  endgenerate

  assign collisionOccurred = coll_out_reg;
  assign holeHit           = hole_out_reg;
  assign resultValid       = valid_reg;
  assign busy              = busy_reg;

endmodule

// File: tb/tb_multi_ball_hit_controller.sv
// Self-checking bench for multi_ball_hit_controller: directed scenarios plus
// randomized frames compared against a loop-based frame model.
module tb_multi_ball_hit_controller;
  localparam int N      = 4;
  localparam int P      = N * (N - 1) / 2;
  localparam int BS     = 32;
  localparam int TOP    = 0;
  localparam int DOWN   = 479;
  localparam int LEFT   = 0;
  localparam int RIGHT  = 639;
  localparam int MARGIN = 4;

  logic             clk, resetN, startOfFrame;
  logic [N-1:0]     ballDR;
  logic             bordersDR, holesDR;
  logic [2:0]       holeNumber;
  logic [11*N-1:0]  ballPosX, ballPosY, ballVelX, ballVelY;
  logic [11*N-1:0]  ballVelXOut, ballVelYOut;
  logic [N-1:0]     collisionOccurred, holeHit;
  logic [3*N-1:0]   holeNum;
  logic             resultValid, busy;

  multi_ball_hit_controller #(
    .NUM_BALLS(N), .BALL_SIZE(BS), .TOP_OFFSET(TOP), .DOWN_OFFSET(DOWN),
    .LEFT_OFFSET(LEFT), .RIGHT_OFFSET(RIGHT), .EDGE_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
    .bordersDR(bordersDR), .holesDR(holesDR), .holeNumber(holeNumber),
    .ballPosX(ballPosX), .ballPosY(ballPosY), .ballVelX(ballVelX), .ballVelY(ballVelY),
    .ballVelXOut(ballVelXOut), .ballVelYOut(ballVelYOut),
    .collisionOccurred(collisionOccurred), .holeHit(holeHit), .holeNum(holeNum),
    .resultValid(resultValid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int frame_no = 0;

  // Current input values driven on the ports
  int m_px[N], m_py[N], m_vx[N], m_vy[N];
  // Values captured at startOfFrame
  int s_px[N], s_py[N], s_vx[N], s_vy[N];
  // Events seen during the frame being collected
  bit m_border[N], m_hole[N];
  int m_hn[N];
  bit m_pair[N][N];
  // Expected published outputs (current) and next-frame results
  int e_vx[N], e_vy[N], e_coll[N], e_hh[N], e_hn[N];
  int n_vx[N], n_vy[N], n_coll[N], n_hh[N], n_hn[N];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx11(input logic [10:0] v);
    return int'($signed(v));
  endfunction

  function automatic int neg_sat(input int v);
    return (v == -1024) ? 1023 : -v;
  endfunction

  function automatic int rand_pos(input bit is_x);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 8));
      1:       return is_x ? int'($urandom_range(596, 639)) : int'($urandom_range(436, 479));
      2:       return int'($urandom_range(0, 2047));
      default: return int'($urandom_range(100, 400));
    endcase
  endfunction

  function automatic int rand_vel();
    case ($urandom_range(0, 4))
      0:       return -1024;
      1:       return 1023;
      2:       return int'($urandom_range(0, 4)) - 2;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      ballPosX[i*11 +: 11] = m_px[i][10:0];
      ballPosY[i*11 +: 11] = m_py[i][10:0];
      ballVelX[i*11 +: 11] = m_vx[i][10:0];
      ballVelY[i*11 +: 11] = m_vy[i][10:0];
    end
  endtask

  task automatic randomize_balls();
    for (int i = 0; i < N; i++) begin
      m_px[i] = rand_pos(1'b1);
      m_py[i] = rand_pos(1'b0);
      m_vx[i] = rand_vel();
      m_vy[i] = rand_vel();
    end
  endtask

  task automatic set_mid();
    for (int i = 0; i < N; i++) begin
      m_px[i] = 150 + 70 * i;
      m_py[i] = 200;
      m_vx[i] = i + 1;
      m_vy[i] = -(i + 1);
    end
  endtask

  task automatic clear_flags();
    for (int i = 0; i < N; i++) begin
      m_border[i] = 1'b0;
      m_hole[i]   = 1'b0;
      m_hn[i]     = 0;
      for (int j = 0; j < N; j++) m_pair[i][j] = 1'b0;
    end
  endtask

  task automatic record_event(input logic [N-1:0] dr, input logic b, input logic h,
                              input logic [2:0] hn);
    for (int i = 0; i < N; i++) begin
      if (dr[i] && b) m_border[i] = 1'b1;
      if (dr[i] && h) begin
        if (!m_hole[i]) m_hn[i] = int'(hn);
        m_hole[i] = 1'b1;
      end
      for (int j = i + 1; j < N; j++)
        if (dr[i] && dr[j]) m_pair[i][j] = 1'b1;
    end
  endtask

  task automatic set_events(input logic [N-1:0] dr, input logic b, input logic h,
                            input logic [2:0] hn);
    ballDR = dr; bordersDR = b; holesDR = h; holeNumber = hn;
  endtask

  // Frame result from the rules: pairs in order, then hole > pair > border
  task automatic compute_expected();
    int vx[N], vy[N], t;
    bit cl[N];
    for (int i = 0; i < N; i++) begin
      vx[i] = s_vx[i]; vy[i] = s_vy[i]; cl[i] = 1'b0;
    end
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++)
        if (m_pair[i][j] && !m_hole[i] && !m_hole[j] && !cl[i] && !cl[j]) begin
          t = vx[i]; vx[i] = vx[j]; vx[j] = t;
          t = vy[i]; vy[i] = vy[j]; vy[j] = t;
          cl[i] = 1'b1; cl[j] = 1'b1;
        end
    for (int i = 0; i < N; i++) begin
      n_hh[i] = 0; n_hn[i] = 0; n_coll[i] = 0;
      n_vx[i] = vx[i]; n_vy[i] = vy[i];
      if (m_hole[i]) begin
        n_vx[i] = 0; n_vy[i] = 0; n_hh[i] = 1; n_hn[i] = m_hn[i];
      end else if (cl[i]) begin
        n_coll[i] = 1;
      end else if (m_border[i]) begin
        n_coll[i] = 1;
        if ((s_px[i] <= LEFT + MARGIN && vx[i] < 0) ||
            (s_px[i] + BS - 1 >= RIGHT - MARGIN && vx[i] > 0)) n_vx[i] = neg_sat(vx[i]);
        if ((s_py[i] <= TOP + MARGIN && vy[i] < 0) ||
            (s_py[i] + BS - 1 >= DOWN - MARGIN && vy[i] > 0)) n_vy[i] = neg_sat(vy[i]);
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s vx%0d", pfx, i), sx11(ballVelXOut[i*11 +: 11]), e_vx[i]);
      check_val($sformatf("%s vy%0d", pfx, i), sx11(ballVelYOut[i*11 +: 11]), e_vy[i]);
      check_val($sformatf("%s coll%0d", pfx, i), int'(collisionOccurred[i]), e_coll[i]);
      check_val($sformatf("%s hole%0d", pfx, i), int'(holeHit[i]), e_hh[i]);
      check_val($sformatf("%s hnum%0d", pfx, i), int'(holeNum[i*3 +: 3]), e_hn[i]);
    end
  endtask

  task automatic zero_expected();
    for (int i = 0; i < N; i++) begin
      e_vx[i] = 0; e_vy[i] = 0; e_coll[i] = 0; e_hh[i] = 0; e_hn[i] = 0;
    end
  endtask

  task automatic collect_cycle(input logic [N-1:0] dr, input logic b, input logic h,
                               input logic [2:0] hn);
    startOfFrame = 1'b0;
    set_events(dr, b, h, hn);
    record_event(dr, b, h, hn);
    @(posedge clk); #1;
  endtask

  // startOfFrame (with an optional coincident event), then the busy window
  // with ignored traffic, then the result strobe and one hold cycle
  task automatic run_frame(input string name, input logic [N-1:0] dr, input logic b,
                           input logic h, input logic [2:0] hn);
    apply_inputs();
    set_events(dr, b, h, hn);
    startOfFrame = 1'b1;
    record_event(dr, b, h, hn);
    for (int i = 0; i < N; i++) begin
      s_px[i] = m_px[i]; s_py[i] = m_py[i]; s_vx[i] = m_vx[i]; s_vy[i] = m_vy[i];
    end
    compute_expected();
    clear_flags();
    @(posedge clk); #1;
    for (int k = 1; k <= P + 1; k++) begin
      check_val($sformatf("%s busy@%0d", name, k), int'(busy), 1);
      check_val($sformatf("%s valid@%0d", name, k), int'(resultValid), 0);
      if (k == P + 1) check_outputs({name, " hold"});
      startOfFrame = ($urandom_range(0, 3) == 0);
      set_events(N'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      randomize_balls();
      apply_inputs();
      @(posedge clk); #1;
    end
    startOfFrame = 1'b0;
    set_events('0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < N; i++) begin
      e_vx[i] = n_vx[i]; e_vy[i] = n_vy[i]; e_coll[i] = n_coll[i];
      e_hh[i] = n_hh[i]; e_hn[i] = n_hn[i];
    end
    check_val({name, " valid"}, int'(resultValid), 1);
    check_val({name, " busy_end"}, int'(busy), 0);
    check_outputs(name);
    frame_no++;
    $display("frame %0d %s: coll=%b hole=%b vx0=%0d vx1=%0d vx2=%0d vx3=%0d", frame_no, name,
             collisionOccurred, holeHit, e_vx[0], e_vx[1], e_vx[2], e_vx[3]);
    @(posedge clk); #1;
    check_val({name, " valid_drop"}, int'(resultValid), 0);
    check_val({name, " after vx0"}, sx11(ballVelXOut[10:0]), e_vx[0]);
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    set_events('0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < N; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
    end
    apply_inputs();
    clear_flags();
    zero_expected();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check_val("reset busy", int'(busy), 0);
    check_val("reset valid", int'(resultValid), 0);
    @(negedge clk) resetN = 1'b1;
    @(posedge clk); #1;

    // Idle frame: velocities pass through untouched
    randomize_balls();
    run_frame("idle", '0, 1'b0, 1'b0, 3'd0);

    // Balls 0 and 1 overlap for three pixels
    set_mid();
    m_vx[0] = 5;  m_vy[0] = 0;
    m_vx[1] = -2; m_vy[1] = 1;
    repeat (3) collect_cycle(4'b0011, 1'b0, 1'b0, 3'd0);
    run_frame("swap01", '0, 1'b0, 1'b0, 3'd0);

    // Ball 2 at the left cushion, event arrives together with startOfFrame
    set_mid();
    m_px[2] = 2; m_vx[2] = -7; m_vy[2] = 3;
    run_frame("border2", 4'b0100, 1'b1, 1'b0, 3'd0);

    // Ball 3 drops into hole 5 and also touches ball 0; later hole index ignored
    set_mid();
    collect_cycle(4'b1000, 1'b0, 1'b1, 3'd5);
    collect_cycle(4'b1001, 1'b0, 1'b0, 3'd0);
    collect_cycle(4'b1000, 1'b0, 1'b1, 3'd2);
    run_frame("hole3", '0, 1'b0, 1'b0, 3'd0);

    // Ball 0 touches 1 and 2: only the first pair swaps
    set_mid();
    collect_cycle(4'b0011, 1'b0, 1'b0, 3'd0);
    collect_cycle(4'b0101, 1'b0, 1'b0, 3'd0);
    run_frame("pairs", '0, 1'b0, 1'b0, 3'd0);

    // Saturating negation at the left cushion
    set_mid();
    m_px[1] = 0; m_vx[1] = -1024;
    collect_cycle(4'b0010, 1'b1, 1'b0, 3'd0);
    run_frame("sat", '0, 1'b0, 1'b0, 3'd0);

    // Reset in the middle of RESOLVE wipes everything and yields no result
    set_mid();
    apply_inputs();
    collect_cycle(4'b0011, 1'b1, 1'b0, 3'd0);
    startOfFrame = 1'b1;
    set_events('0, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    zero_expected();
    clear_flags();
    check_outputs("midreset");
    check_val("midreset busy", int'(busy), 0);
    check_val("midreset valid", int'(resultValid), 0);
    @(negedge clk) resetN = 1'b1;
    for (int k = 0; k < P + 3; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("postreset valid@%0d", k), int'(resultValid), 0);
      check_val($sformatf("postreset busy@%0d", k), int'(busy), 0);
    end
    $display("frame %0d midreset: outputs cleared", frame_no);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      int ncyc;
      randomize_balls();
      ncyc = int'($urandom_range(0, 12));
      for (int c = 0; c < ncyc; c++)
        collect_cycle(N'($urandom) & N'($urandom), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 6) == 0), 3'($urandom));
      run_frame($sformatf("rand%0d", f), N'($urandom) & N'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_ball_hit_controller.md
# multi_ball_hit_controller

Frame-based collision arbiter for up to eight balls, replacing the fixed two-ball hit controller in the billiard physics path. It accumulates per-pixel overlap events between ball, border and hole drawing requests over one video frame. On the start-of-frame pulse it resolves them sequentially: ball-to-ball pairs one per cycle, then borders and holes. It then publishes one registered, prioritised velocity update per ball to the ball movement modules.

## Interface
- NUM_BALLS, 4, number of balls, legal 2..8; P = NUM_BALLS*(NUM_BALLS-1)/2 pairs
- BALL_SIZE, 32, ball bounding-box side in pixels
- TOP_OFFSET / DOWN_OFFSET / LEFT_OFFSET / RIGHT_OFFSET, 0 / 479 / 0 / 639, table cushion coordinates
- EDGE_MARGIN, 4, pixel tolerance for deciding which cushion was hit
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- ballDR  in  NUM_BALLS  per-ball drawing request, bit i = ball i
- bordersDR  in  1  cushion drawing request
- holesDR  in  1  hole drawing request
- holeNumber  in  3  index of the hole currently drawn
- ballPosX, ballPosY  in  11*NUM_BALLS  unsigned top-left positions, slice i = ball i
- ballVelX, ballVelY  in  11*NUM_BALLS  signed velocities
- ballVelXOut, ballVelYOut  out  11*NUM_BALLS  signed resolved velocities
- collisionOccurred  out  NUM_BALLS  ball bounced this frame
- holeHit  out  NUM_BALLS  ball entered a hole this frame
- holeNum  out  3*NUM_BALLS  hole index per ball
- resultValid  out  1  one-cycle strobe: outputs updated
- busy  out  1  high in RESOLVE and APPLY

## Operation
- States: COLLECT (reset), RESOLVE, APPLY.
- COLLECT, every cycle, sticky flags:
  - borderHit[i] |= ballDR[i]&bordersDR.
  - holePend[i] |= ballDR[i]&holesDR. holeNumber is latched only on the first such cycle of the frame.
  - pairHit[i][j] (i<j) |= ballDR[i]&ballDR[j].
- startOfFrame in COLLECT:
  - Snapshot all positions and velocities into working registers.
  - pairIdx=0; go to RESOLVE.
  - Flags for the finished frame are frozen. Flags are cleared on exit from APPLY.
- RESOLVE processes one pair per cycle in lexicographic order (0,1),(0,2)..(0,N-1),(1,2)..
  - Condition: pairHit set, neither ball has holePend, neither ball claimed.
  - If met: swap both velocity components of the pair in the working registers, mark both claimed, set collision for both.
  - After pair P-1, go to APPLY.
- APPLY (one cycle), per ball, priority hole > pair > border:
  - Hole: velocities forced to 0, holeHit=1, collision=0.
  - Border, not claimed, not hole:
    - velX is negated if (posX <= LEFT_OFFSET+EDGE_MARGIN and velX<0) or (posX+BALL_SIZE-1 >= RIGHT_OFFSET-EDGE_MARGIN and velX>0).
    - Y uses TOP/DOWN the same way.
    - collision=1 even if no component is negated.
  - Otherwise the velocity passes through unchanged (no zeroing of idle balls).
  - All outputs are registered at the end of APPLY. Then return to COLLECT with flags cleared.
- Negation saturates: -1024 becomes +1023.
- Position arithmetic is carried out in 12 bits unsigned; no wrap.
- startOfFrame while busy is ignored. DR inputs are ignored while busy; events in those cycles are lost.

## Timing
- Reset: all outputs 0, resultValid=0, busy=0, flags cleared, state COLLECT.
- startOfFrame high in cycle T:
  - busy is high in T+1..T+P+1.
  - resultValid is high in exactly cycle T+P+2, with outputs valid from then on. N=2 gives T+3; N=4 gives T+8.
- Outputs hold their values until the next resultValid.
- Reset asserted mid-RESOLVE: immediate return to reset values. No partial results appear.
- startOfFrame coincident with a DR event: that event counts toward the ending frame.

## Test plan
- Reset with N=4, all DR idle, startOfFrame at T -> resultValid at T+8. Outputs equal the input velocities, all collision/holeHit bits 0.
- Balls 0 and 1 overlap for 3 pixels, vel0=(5,0), vel1=(-2,1) -> out0=(-2,1), out1=(5,0), collisionOccurred=0011.
- Ball 2 at posX=2 with velX=-7 overlaps bordersDR -> velXOut2=+7, velY unchanged, collisionOccurred[2]=1.
- Ball 3 overlaps holesDR with holeNumber=5 and also overlaps ball 0 -> ball3 velocity (0,0), holeHit[3]=1, holeNum3=5. Ball 0 is unchanged with no collision.
- Pairs (0,1) and (0,2) both hit -> only (0,1) swaps. Ball 2 keeps its velocity, collision[2]=0.
- velX=-1024 at the left cushion -> +1023. Reset asserted during RESOLVE -> outputs 0, no resultValid.
